// File: rtl/spi_frame_master.sv
// spi_frame_master: SPI master that runs one multi-byte full-duplex frame per start pulse.
// Ports: CLK/RST, start+tx_data request, MISO in; SS/SCLK/MOSI out, rx_data/busy/done status.
module spi_frame_master #(
  parameter int HALF_DIV = 750,
  parameter int N_BYTES  = 5,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0,
  parameter int SS_SETUP = 2,
  parameter int BYTE_GAP = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [8*N_BYTES-1:0] tx_data,
  input  logic                 MISO,
  output logic                 SS,
  output logic                 SCLK,
  output logic                 MOSI,
  output logic [8*N_BYTES-1:0] rx_data,
  output logic                 busy,
  output logic                 done
);

  localparam int NB   = 8 * N_BYTES;
  localparam int HW   = $clog2(HALF_DIV);
  localparam int TM1  = (SS_SETUP > 16) ? SS_SETUP : 16;
  localparam int TMAX = (BYTE_GAP > TM1) ? BYTE_GAP : TM1;
  localparam int CW   = $clog2(TMAX);
  localparam int BW   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  localparam logic POL = (CPOL != 0);
  localparam logic PHA = (CPHA != 0);

  localparam logic [HW-1:0] HMAX  = HW'(HALF_DIV - 1);
  localparam logic [CW-1:0] SMAX  = CW'(SS_SETUP - 1);
  localparam logic [CW-1:0] GMAX  = CW'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);
  localparam logic [CW-1:0] BEND  = CW'(15);
  localparam logic [BW-1:0] BLAST = BW'(N_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    GAP,
    HOLD,
    FIN
  } state_t;

  state_t        state;
  logic [HW-1:0] hcnt;
  logic [CW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic [NB-1:0] tx_sr;
  logic [NB-1:0] rx_sr;
  logic          tick;
  logic          smp;
  logic          lastb;

  assign tick  = (hcnt == HMAX);
  // even tcnt is a leading edge; CPHA flips which edge samples
  assign smp   = (~tcnt[0]) ^ PHA;
  assign lastb = (bcnt == BLAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      hcnt    <= '0;
      tcnt    <= '0;
      bcnt    <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      SS      <= 1'b1;
      SCLK    <= POL;
      MOSI    <= 1'b0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      hcnt <= (state == IDLE || tick) ? '0 : hcnt + HW'(1);
      case (state)
        IDLE: begin
          // a start landing in the done cycle is dropped
          if (start && !done) begin
            state <= SETUP;
            SS    <= 1'b0;
            busy  <= 1'b1;
            MOSI  <= tx_data[NB-1];
            // tx_sr holds the bits still to be driven
            tx_sr <= PHA ? tx_data : {tx_data[NB-2:0], 1'b0};
            tcnt  <= '0;
            bcnt  <= '0;
          end
        end
        SETUP: begin
          if (tick) begin
            if (tcnt == SMAX) begin
              tcnt  <= '0;
              state <= XFER;
            end else begin
              tcnt <= tcnt + CW'(1);
            end
          end
        end
        XFER: begin
          if (tick) begin
            SCLK <= ~SCLK;
            if (smp) begin
              rx_sr <= {rx_sr[NB-2:0], MISO};
            end else if (!(lastb && tcnt == BEND)) begin
              MOSI  <= tx_sr[NB-1];
              tx_sr <= {tx_sr[NB-2:0], 1'b0};
            end
            if (tcnt == BEND) begin
              tcnt <= '0;
              if (lastb) begin
                state <= HOLD;
              end else begin
                bcnt  <= bcnt + BW'(1);
                state <= (BYTE_GAP == 0) ? XFER : GAP;
              end
            end else begin
              tcnt <= tcnt + CW'(1);
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (tcnt == GMAX) begin
              tcnt  <= '0;
              state <= XFER;
            end else begin
              tcnt <= tcnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state <= FIN;
          end
        end
        FIN: begin
          state   <= IDLE;
          SS      <= 1'b1;
          MOSI    <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
          rx_data <= rx_sr;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master: three configurations of spi_frame_master run side by side.
// Vector table + scoreboard for mode 3, loopback for defaults, corner sequences on a tiny frame.
module tb_spi_frame_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // A: defaults, MISO looped back to MOSI
  logic        rst_a = 1'b1;
  logic        start_a = 1'b0;
  logic [39:0] tx_a = '0;
  logic [39:0] rx_a;
  logic        ss_a, sclk_a, mosi_a, busy_a, done_a;

  spi_frame_master ua (
    .CLK(clk), .RST(rst_a), .start(start_a), .tx_data(tx_a),
    .MISO(mosi_a), .SS(ss_a), .SCLK(sclk_a), .MOSI(mosi_a),
    .rx_data(rx_a), .busy(busy_a), .done(done_a)
  );

  // B: mode 3, two bytes, slave model
  logic        rst_b = 1'b1;
  logic        start_b = 1'b0;
  logic [15:0] tx_b = '0;
  logic        miso_b = 1'b0;
  logic [15:0] rx_b;
  logic        ss_b, sclk_b, mosi_b, busy_b, done_b;

  spi_frame_master #(
    .HALF_DIV(4), .N_BYTES(2), .CPOL(1), .CPHA(1)
  ) ub (
    .CLK(clk), .RST(rst_b), .start(start_b), .tx_data(tx_b),
    .MISO(miso_b), .SS(ss_b), .SCLK(sclk_b), .MOSI(mosi_b),
    .rx_data(rx_b), .busy(busy_b), .done(done_b)
  );

  // C: one byte, no gap, fastest clock
  logic       rst_c = 1'b1;
  logic       start_c = 1'b0;
  logic [7:0] tx_c = '0;
  logic       miso_c = 1'b0;
  logic [7:0] rx_c;
  logic       ss_c, sclk_c, mosi_c, busy_c, done_c;

  spi_frame_master #(
    .HALF_DIV(2), .N_BYTES(1), .BYTE_GAP(0)
  ) uc (
    .CLK(clk), .RST(rst_c), .start(start_c), .tx_data(tx_c),
    .MISO(miso_c), .SS(ss_c), .SCLK(sclk_c), .MOSI(mosi_c),
    .rx_data(rx_c), .busy(busy_c), .done(done_c)
  );

  // mode 3 slave: drive on falling SCLK, capture on rising SCLK
  logic [15:0] slv_tx = '0;
  logic [15:0] cap_b = '0;
  logic [4:0]  bi = '0;

  always @(negedge sclk_b or negedge ss_b) begin
    if (ss_b === 1'b0) begin
      if (sclk_b === 1'b1) begin
        bi = 5'd15;
      end else begin
        miso_b = slv_tx[bi[3:0]];
        bi = bi - 5'd1;
      end
    end
  end

  always @(posedge sclk_b) begin
    if (ss_b === 1'b0) cap_b = {cap_b[14:0], mosi_b};
  end

  int rises_a = 0;
  always @(posedge sclk_a) begin
    if (ss_a === 1'b0) rises_a++;
  end

  // scoreboards
  typedef struct {
    logic [15:0] rx;
    logic [15:0] cap;
  } exp_b_t;

  exp_b_t     sb_b[$];
  logic [7:0] sb_c[$];
  int         done_c_n = 0;
  int         pushed_c = 0;
  int         acc_c = 0;

  // SCLK/SS protocol watch, one slot per instance
  logic [2:0] pss, psc;
  int         low[3];
  bit         arm[3];
  int         falls[3];

  task automatic t6(input int i, input logic ss, input logic sc,
                    input int min);
    if (!$isunknown({ss, sc})) begin
      if (!ss && pss[i] === 1'b1) falls[i]++;
      low[i] = ss ? 0 : low[i] + 1;
      if (!$isunknown(psc[i]) && sc !== psc[i]) begin
        checks++;
        if (ss && pss[i] === 1'b1) begin
          errors++;
          $display("FAIL t6_sclk_ss%0d: SCLK moved with SS=1, required SS=0", i);
        end
        if (!ss && arm[i]) begin
          checks++;
          arm[i] = 1'b0;
          if (low[i] <= min) begin
            errors++;
            $display("FAIL t6_setup%0d: SS low %0d cycles, required >= %0d",
                     i, low[i] - 1, min);
          end
        end
      end
      if (ss) arm[i] = 1'b1;
      pss[i] = ss;
      psc[i] = sc;
    end
  endtask

  always @(negedge clk) begin
    t6(0, ss_a, sclk_a, 1500);
    t6(1, ss_b, sclk_b, 8);
    t6(2, ss_c, sclk_c, 4);
    if (done_b === 1'b1) begin
      if (sb_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_b_empty: got done, required none");
      end else begin
        exp_b_t e;
        e = sb_b.pop_front();
        check("t3_rx", rx_b, e.rx);
        check("t3_cap", cap_b, e.cap);
      end
    end
    if (done_c === 1'b1) begin
      done_c_n++;
      if (sb_c.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_c_empty: got done, required none");
      end else begin
        check("sb_c_rx", rx_c, sb_c.pop_front());
      end
    end
  end

  typedef struct {
    logic [15:0] tx;
    logic [15:0] slv;
    logic [15:0] rx;
    logic [15:0] cap;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs[NV];

  task automatic frame_c(input logic [7:0] tx, input logic mi,
                         output int nbusy, output int nrise);
    logic p;
    miso_c = mi;
    sb_c.push_back(mi ? 8'hFF : 8'h00);
    pushed_c++;
    acc_c++;
    @(negedge clk);
    tx_c = tx;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    nbusy = 0;
    nrise = 0;
    p = sclk_c;
    for (int i = 0; i < 200 && done_c !== 1'b1; i++) begin
      if (busy_c === 1'b1) nbusy++;
      if (sclk_c === 1'b1 && p === 1'b0) nrise++;
      p = sclk_c;
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0] = '{tx: 16'h3CC3, slv: 16'hA55A, rx: 16'hA55A, cap: 16'h3CC3};
    vecs[1] = '{tx: 16'h0000, slv: 16'hFFFF, rx: 16'hFFFF, cap: 16'h0000};
    vecs[2] = '{tx: 16'hFFFF, slv: 16'h0000, rx: 16'h0000, cap: 16'hFFFF};
    vecs[3] = '{tx: 16'h8001, slv: 16'h1234, rx: 16'h1234, cap: 16'h8001};
    vecs[4] = '{tx: 16'h5AA5, slv: 16'h0F0F, rx: 16'h0F0F, cap: 16'h5AA5};

    fork
      begin : thr_a
        int n;
        repeat (3) @(negedge clk);
        check("t2_rst_ss", ss_a, 1);
        check("t2_rst_sclk", sclk_a, 0);
        check("t2_rst_busy", busy_a, 0);
        check("t2_rst_rx", rx_a, 0);
        rst_a = 1'b0;
        @(negedge clk);
        tx_a = 40'h8C11223344;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        tx_a = '0;
        check("t2_busy", busy_a, 1);
        check("t2_mosi_msb", mosi_a, 1);
        n = 0;
        while (done_a !== 1'b1 && n < 70000) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("t2_latency", n, 68251);
        check("t2_rx", rx_a, 40'h8C11223344);
        check("t2_rises", rises_a, 40);
        check("t2_ss_end", ss_a, 1);
        @(negedge clk);
        @(negedge clk);
        check("t2_done_pulse", done_a, 0);
      end

      begin : thr_b
        vec_t v;
        int n;
        repeat (3) @(negedge clk);
        check("t3_rst_sclk", sclk_b, 1);
        check("t3_rst_ss", ss_b, 1);
        rst_b = 1'b0;
        for (int k = 0; k < NV; k++) begin
          v = vecs[k];
          slv_tx = v.slv;
          sb_b.push_back('{rx: v.rx, cap: v.cap});
          @(negedge clk);
          tx_b = v.tx;
          start_b = 1'b1;
          @(posedge clk);
          #1;
          start_b = 1'b0;
          tx_b = ~v.tx;
          n = 0;
          while (done_b !== 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
          end
          check("t3_latency", n, 149);
          @(negedge clk);
          check("t3_idle_sclk", sclk_b, 1);
          repeat (3) @(negedge clk);
        end
        check("t3_sb_left", sb_b.size(), 0);
      end

      begin : thr_c
        int nb, nr, d0, f0, e, freeat, nacc;
        repeat (3) @(negedge clk);
        check("t1_rst_ss", ss_c, 1);
        check("t1_rst_sclk", sclk_c, 0);
        check("t1_rst_mosi", mosi_c, 0);
        check("t1_rst_busy", busy_c, 0);
        check("t1_rst_done", done_c, 0);
        check("t1_rst_rx", rx_c, 0);
        rst_c = 1'b0;
        @(negedge clk);

        frame_c(8'hA5, 1'b1, nb, nr);
        check("c_busy_1", nb, 39);
        check("c_rises_1", nr, 8);
        frame_c(8'hFF, 1'b0, nb, nr);
        check("t5_busy", nb, 39);
        check("t5_rises", nr, 8);
        frame_c(8'hFF, 1'b1, nb, nr);
        check("c_busy_3", nb, 39);
        repeat (3) @(negedge clk);

        // abort a frame with reset while SCLK and MOSI are high
        miso_c = 1'b1;
        acc_c++;
        @(negedge clk);
        tx_c = 8'hFF;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        for (int i = 0; i < 40 && !(sclk_c === 1'b1 && mosi_c === 1'b1); i++)
          @(negedge clk);
        check("t1_pre_sclk", sclk_c, 1);
        check("t1_pre_rx", rx_c, 8'hFF);
        d0 = done_c_n;
        #2;
        rst_c = 1'b1;
        #1;
        check("t1_mid_ss", ss_c, 1);
        check("t1_mid_sclk", sclk_c, 0);
        check("t1_mid_mosi", mosi_c, 0);
        check("t1_mid_busy", busy_c, 0);
        check("t1_mid_rx", rx_c, 0);
        @(negedge clk);
        rst_c = 1'b0;
        repeat (60) @(negedge clk);
        check("t1_no_done", done_c_n, d0);

        // start every 10 cycles; a small model predicts acceptance
        miso_c = 1'b1;
        d0 = done_c_n;
        f0 = falls[2];
        freeat = 0;
        nacc = 0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          start_c = 1'b1;
          tx_c = 8'h00;
          e = cyc + 1;
          if (e >= freeat) begin
            sb_c.push_back(8'hFF);
            pushed_c++;
            acc_c++;
            nacc++;
            freeat = e + 2 * 19 + 3;
          end
          @(negedge clk);
          start_c = 1'b0;
          repeat (8) @(negedge clk);
        end
        repeat (100) @(negedge clk);
        check("t4_dones", done_c_n - d0, nacc);
        check("t4_ss_periods", falls[2] - f0, nacc);
      end
    join

    check("t6_ss_periods_a", falls[0], 1);
    check("t6_ss_periods_b", falls[1], NV);
    check("t6_ss_periods_c", falls[2], acc_c);
    check("c_dones_total", done_c_n, pushed_c);
    check("c_sb_left", sb_c.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
